// File: rtl/pmem_scheduler.sv
// Arbiter sharing one cacheline-wide memory port between I-cache, D-cache and
// next-line prefetcher, with I-side anti-starvation and I/PF miss coalescing.
module pmem_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic [255:0] pf_rdata,
  output logic         pf_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, GNT_PF} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t       state_q, state_d;
  logic [3:0]   starve_cnt_q, starve_cnt_d;
  logic         coal_q, coal_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [31:0]  mem_address_q, mem_address_d;
  logic [255:0] mem_wdata_q, mem_wdata_d;

  logic d_req, pf_same_line, gnt_i_sel, gnt_d_sel, gnt_pf_sel;
  logic unused_addr_bits;

  assign d_req            = d_read | d_write;
  assign pf_same_line     = pf_read && (pf_address[31:5] == i_address[31:5]);
  assign unused_addr_bits = ^{i_address[4:0], d_address[4:0], pf_address[4:0]};

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    coal_d        = coal_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (!i_read) starve_cnt_d = '0;
        // I wins when it has been starved long enough or when D is not asking
        if (i_read && (starve_cnt_q == LIMIT || !d_req)) begin
          state_d       = GNT_I;
          starve_cnt_d  = '0;
          coal_d        = pf_same_line;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = {i_address[31:5], 5'b0};
          mem_wdata_d   = '0;
        end else if (d_req) begin
          state_d       = GNT_D;
          if (i_read && starve_cnt_q != 4'hF) starve_cnt_d = starve_cnt_q + 4'd1;
          coal_d        = 1'b0;
          mem_read_d    = d_read & ~d_write;
          mem_write_d   = d_write;
          mem_address_d = {d_address[31:5], 5'b0};
          mem_wdata_d   = d_wdata;
        end else if (pf_read) begin
          state_d       = GNT_PF;
          coal_d        = 1'b0;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = {pf_address[31:5], 5'b0};
          mem_wdata_d   = '0;
        end
      end
      default: begin
        if (mem_resp) begin
          state_d       = IDLE;
          coal_d        = 1'b0;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          mem_address_d = '0;
          mem_wdata_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      coal_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      coal_q        <= coal_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // A coalesced prefetch rides along on the I grant
  assign gnt_i_sel  = (state_q == GNT_I);
  assign gnt_d_sel  = (state_q == GNT_D);
  assign gnt_pf_sel = (state_q == GNT_PF) | (gnt_i_sel & coal_q);

  assign i_resp   = gnt_i_sel & mem_resp;
  assign d_resp   = gnt_d_sel & mem_resp;
  assign pf_resp  = gnt_pf_sel & mem_resp;
  assign i_rdata  = gnt_i_sel  ? mem_rdata : '0;
  assign d_rdata  = gnt_d_sel  ? mem_rdata : '0;
  assign pf_rdata = gnt_pf_sel ? mem_rdata : '0;

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
endmodule

// File: doc/pmem_scheduler.md
# pmem_scheduler

Shares the single physical-memory port among the I-cache, the D-cache and the next-line instruction prefetcher. Requests are arbitrated by priority with an aging counter that prevents I-side starvation. Command, address and write data are latched at grant so the memory bus never glitches. An I-side miss and a prefetch to the same line are coalesced into one memory transaction. The block sits between the L1 caches/prefetcher and the cacheline-wide physical memory (or L2).

## Interface
- STARVE_LIMIT, 4: consecutive D grants allowed while `i_read` is pending before I is forced; legal range 1–15.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_read  in  1  I-cache line read request
- i_address  in  32  I-cache request address
- i_rdata  out  256  line data to I-cache
- i_resp  out  1  I-cache transaction done
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write-back request
- d_address  in  32  D-cache request address
- d_wdata  in  256  D-cache write-back data
- d_rdata  out  256  line data to D-cache
- d_resp  out  1  D-cache transaction done
- pf_read  in  1  prefetcher line read request
- pf_address  in  32  prefetch address
- pf_rdata  out  256  line data to prefetcher
- pf_resp  out  1  prefetch transaction done
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_address  out  32  memory line address; [4:0] always 0
- mem_wdata  out  256  memory write data
- mem_rdata  in  256  memory read data
- mem_resp  in  1  memory transaction done

## Operation
- States: IDLE, GNT_I, GNT_D, GNT_PF.
- IDLE arbitration, first match wins:
  1. `i_read` and starve_cnt == STARVE_LIMIT → GNT_I.
  2. `d_read|d_write` → GNT_D, and starve_cnt increments (saturating) if `i_read` is high.
  3. `i_read` → GNT_I.
  4. `pf_read` → GNT_PF.
  5. Otherwise stay in IDLE.
- starve_cnt (4 bits):
  - cleared on any GNT_I entry.
  - cleared in IDLE when `i_read` is low.
- Grant entry latches cmd/address/wdata from the winner into registers. `mem_*` outputs are driven only from these registers and are held constant for the whole grant.
- D with `d_read` and `d_write` both high: issued as a write; `mem_read` = 0.
- Coalescing: an I grant with `pf_read` high and `pf_address[31:5] == i_address[31:5]` sets a registered coalesce flag. On `mem_resp`, both `i_resp` and `pf_resp` pulse and both rdata ports carry `mem_rdata`.
- In GNT_x:
  - x_resp = `mem_resp` (combinational).
  - x_rdata = `mem_rdata`.
  - Non-granted rdata ports are 0; non-granted resp signals are 0.
- On `mem_resp` the state returns to IDLE. A GNT_x → GNT_y transition without passing through IDLE is not allowed.
- Requesters hold their request stable until their resp, then deassert in the following cycle (the IDLE cycle). Requests that change mid-grant are ignored.
- Reset (any state):
  - state = IDLE; starve_cnt, coalesce flag and latched cmd/address/wdata all cleared.
  - All outputs read 0 in the cycle after the reset edge.
  - Any `mem_resp` from an aborted transaction arrives in IDLE and is ignored.

## Timing
- Request sampled at edge N in IDLE → grant state and `mem_read`/`mem_write` asserted from cycle N+1 (registered command).
- `mem_resp` in cycle M → requester resp in cycle M (zero added latency) → IDLE at M+1 → earliest next command at M+2.
- Minimum occupancy per transaction: 1 arbitration cycle + memory latency + 1 idle cycle.
- `mem_resp` while in IDLE has no effect and produces no resp output.
- `mem_resp` is a single-cycle pulse. A resp held for multiple cycles is not supported and its behaviour is undefined.

## Test plan
- Single D read, addr 0x0000_1234, memory latency 3:
  - `mem_read` = 1 with `mem_address` 0x0000_1220 for cycles 1–4.
  - `d_resp` in cycle 4 with data 0xAB…AB.
  - No I/PF resp at any point.
- Simultaneous `i_read` and `d_write`:
  - D is granted first with `mem_write`=1 and `mem_wdata` = `d_wdata`.
  - After 1 IDLE cycle, I is granted.
  - `i_resp` only follows `d_resp`.
- Starvation, STARVE_LIMIT=2, `d_read` continuously re-asserted with `i_read` held:
  - Grant order is D, D, I, D.
  - starve_cnt reads 0 after the I grant.
- Coalescing: `i_read` 0x400 and `pf_read` 0x41C together:
  - One `mem_read` to 0x400.
  - `i_resp` and `pf_resp` in the same cycle with identical rdata.
  - Non-coalesced check with `pf_address` 0x420: two separate transactions, I first.
- Mid-grant address change: `d_address` changes after grant → `mem_address` holds the latched value until resp.
- Reset asserted during GNT_D with memory latency 5:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A late `mem_resp` produces no `d_resp`.
  - A new `i_read` is granted normally afterwards.
